// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// No logic; no latency.
// No flow control; constants only.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_I_EXEC   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JUMP_REG = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // Mux select encodings
  localparam logic [1:0] SA_PC    = 2'b00;
  localparam logic [1:0] SA_REGA  = 2'b01;
  localparam logic [1:0] SA_SHAMT = 2'b10;

  localparam logic [1:0] SB_REGB   = 2'b00;
  localparam logic [1:0] SB_FOUR   = 2'b01;
  localparam logic [1:0] SB_IMM    = 2'b10;
  localparam logic [1:0] SB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  localparam logic [1:0] MTR_MEM = 2'b00;
  localparam logic [1:0] MTR_ALU = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // ALUOp[2:0] operation codes
  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_FUNCT = 3'b010;
  localparam logic [2:0] AOP_OR    = 3'b011;
  localparam logic [2:0] AOP_AND   = 3'b100;
  localparam logic [2:0] AOP_SLT   = 3'b101;

  // Shifts take their A operand from the shamt field
  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

  // R-type function codes the datapath actually implements
  function automatic logic funct_legal(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR, FN_ADD, FN_ADDU, FN_SUB,
      FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_aluop_decode.sv
// ALU operation select from the current FSM state and latched opcode.
// Purely combinational, zero latency.
// No flow control.
module mc_aluop_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] OpCode,
  input  state_t     i_state,
  output logic [3:0] ALUOp
);

  // Bit 3 carries OpCode[0] only in states where the ALU result is consumed
  always_comb begin
    ALUOp = 4'b0000;
    case (i_state)
      S_MEM_ADDR: ALUOp = {OpCode[0], AOP_ADD};
      S_R_EXEC:   ALUOp = {OpCode[0], AOP_FUNCT};
      S_BRANCH:   ALUOp = {OpCode[0], AOP_SUB};
      S_I_EXEC: begin
        case (OpCode)
          OP_ANDI:          ALUOp = {OpCode[0], AOP_AND};
          OP_ORI:           ALUOp = {OpCode[0], AOP_OR};
          OP_SLTI, OP_SLTIU: ALUOp = {OpCode[0], AOP_SLT};
          default:          ALUOp = {OpCode[0], AOP_ADD};
        endcase
      end
      default: ALUOp = 4'b0000;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM; MC_ILLEGAL_TRAP_EN adds a trap state and `trap` output.
// Moore outputs; 3-5 cycles per instruction plus one per memory wait cycle.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; mem_ready ignored elsewhere.
module multicycle_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [2:0] Branch,
  output logic       instr_done
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       trap
`endif
);

  state_t r_state;
  state_t w_next;

  // State register; reset forces RESET asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RESET;
    else        r_state <= w_next;
  end

  mc_aluop_decode u_aluop (
    .OpCode  (OpCode),
    .i_state (r_state),
    .ALUOp   (ALUOp)
  );

`ifdef MC_ILLEGAL_TRAP_EN
  assign trap = (r_state == S_TRAP);
`endif

  // Next-state and Moore control outputs
  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    MemtoReg    = MTR_MEM;
    RegDst      = RD_RT;
    ALUSrcA     = SA_PC;
    ALUSrcB     = SB_REGB;
    PCSource    = PCS_ALU;
    Branch      = 3'b000;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SB_IMM_SH;
        case (OpCode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE: begin
            if (Funct == FN_JR || Funct == FN_JALR) w_next = S_JUMP_REG;
`ifdef MC_ILLEGAL_TRAP_EN
            else if (!funct_legal(Funct))           w_next = S_TRAP;
`endif
            else                                    w_next = S_R_EXEC;
          end
          OP_J, OP_JAL:                               w_next = S_JUMP;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ:  w_next = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI,
          OP_SLTI, OP_SLTIU, OP_LUI:                  w_next = S_I_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
          default: w_next = S_TRAP;
`else
          default: w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = SA_REGA;
        ALUSrcB = SB_IMM;
        ExtOp   = 1'b1;
        w_next  = (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_R_EXEC: begin
        ALUSrcA = is_shift(Funct) ? SA_SHAMT : SA_REGA;
        w_next  = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        MemtoReg = MTR_ALU;
        // Opcode is held for the whole instruction, so it tells R vs I path
        RegDst   = (OpCode == OP_RTYPE) ? RD_RD : RD_RT;
        w_next   = S_FETCH;
      end
      S_I_EXEC: begin
        ALUSrcA = SA_REGA;
        ALUSrcB = SB_IMM;
        ExtOp   = !(OpCode == OP_ANDI || OpCode == OP_ORI);
        LuiOp   = (OpCode == OP_LUI);
        w_next  = S_ALU_WB;
      end
      S_BRANCH: begin
        ALUSrcA     = SA_REGA;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        Branch      = OpCode[2:0];
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = RD_R31;
          MemtoReg = MTR_PC;
        end
        w_next = S_FETCH;
      end
      S_JUMP_REG: begin
        PCWrite  = 1'b1;
        PCSource = PCS_REGA;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = RD_RD;
          MemtoReg = MTR_PC;
        end
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_RESET;
    endcase
    instr_done = (w_next == S_FETCH) && (r_state != S_RESET) && (r_state != S_FETCH);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller.
// Inputs change on the falling edge; outputs are checked 1ns later.
// Expected control words are hand-built per state.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic [2:0] Branch;
  logic       instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       trap;
`endif

  int checks   = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .OpCode      (OpCode),
    .Funct       (Funct),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .ExtOp       (ExtOp),
    .LuiOp       (LuiOp),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .Branch      (Branch),
    .instr_done  (instr_done)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .trap        (trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [26:0] w_obs;
  assign w_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
                  MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, Branch, instr_done};

  localparam logic [26:0] ZERO = 27'd0;

  function automatic logic [26:0] mk(input logic pcw, pcc, iord, mr, mw, irw, rw, ext, lui,
                                     input logic [1:0] mtr, rd, sa, sb,
                                     input logic [3:0] aop,
                                     input logic [1:0] pcs,
                                     input logic [2:0] br,
                                     input logic done);
    return {pcw, pcc, iord, mr, mw, irw, rw, ext, lui, mtr, rd, sa, sb, aop, pcs, br, done};
  endfunction

  function automatic logic [26:0] e_fetch(input logic rdy);
    return mk(rdy,0,0,1,0,rdy,0,0,0, 2'b00,2'b00,2'b00,2'b01, 4'b0000, 2'b00, 3'b000, 1'b0);
  endfunction

  function automatic logic [26:0] e_decode(input logic done);
    return mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b11, 4'b0000, 2'b00, 3'b000, done);
  endfunction

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [26:0] exp);
    #1;
    checks++;
    assert (w_obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Fetch (ready) then decode for one instruction
  task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
    OpCode = op; Funct = fn; mem_ready = 1'b1;
    chk({tag, "_fetch"}, e_fetch(1'b1));
    adv();
    mem_ready = 1'b0;  // ignored in DECODE
    chk({tag, "_decode"}, e_decode(1'b0));
    adv();
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b0; OpCode = 6'h00; Funct = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_hold", ZERO);
    reset = 1'b1;
    chk("reset_state", ZERO);
    adv();

    // FETCH with one wait cycle
    mem_ready = 1'b0;
    chk("fetch_wait", e_fetch(1'b0));
    adv();

    // add $3,$1,$2
    fetch_decode("add", 6'h00, 6'h20);
    chk("add_rexec", mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 4'b0010, 2'b00, 3'b000, 0));
    adv();
    chk("add_wb", mk(0,0,0,0,0,0,1,0,0, 2'b01,2'b01,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 1));
    adv();

    // lw with two wait cycles in MEM_RD
    fetch_decode("lw", 6'h23, 6'h00);
    chk("lw_addr", mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b10, 4'b1000, 2'b00, 3'b000, 0));
    adv();
    mem_ready = 1'b0;
    chk("lw_rd_w1", mk(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 0));
    adv();
    chk("lw_rd_w2", mk(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 0));
    adv();
    mem_ready = 1'b1;
    chk("lw_rd_rdy", mk(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 0));
    adv();
    chk("lw_wb", mk(0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 1));
    adv();

    // bne
    fetch_decode("bne", 6'h05, 6'h00);
    chk("bne_branch", mk(0,1,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00, 4'b1001, 2'b01, 3'b101, 1));
    adv();

    // jal
    fetch_decode("jal", 6'h03, 6'h00);
    chk("jal_jump", mk(1,0,0,0,0,0,1,0,0, 2'b10,2'b10,2'b00,2'b00, 4'b0000, 2'b10, 3'b000, 1));
    adv();

    // ori: zero-extended immediate, OR
    fetch_decode("ori", 6'h0d, 6'h00);
    chk("ori_iexec", mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b01,2'b10, 4'b1011, 2'b00, 3'b000, 0));
    adv();
    chk("ori_wb", mk(0,0,0,0,0,0,1,0,0, 2'b01,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 1));
    adv();

    // sw with one wait cycle in MEM_WR
    fetch_decode("sw", 6'h2b, 6'h00);
    chk("sw_addr", mk(0,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b10, 4'b1000, 2'b00, 3'b000, 0));
    adv();
    mem_ready = 1'b0;
    chk("sw_wr_wait", mk(0,0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 0));
    adv();
    mem_ready = 1'b1;
    chk("sw_wr_rdy", mk(0,0,1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 1));
    adv();

    // sll: shamt on A input
    fetch_decode("sll", 6'h00, 6'h00);
    chk("sll_rexec", mk(0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10,2'b00, 4'b0010, 2'b00, 3'b000, 0));
    adv();
    chk("sll_wb", mk(0,0,0,0,0,0,1,0,0, 2'b01,2'b01,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 1));
    adv();

    // jalr
    fetch_decode("jalr", 6'h00, 6'h09);
    chk("jalr_jreg", mk(1,0,0,0,0,0,1,0,0, 2'b10,2'b01,2'b00,2'b00, 4'b0000, 2'b11, 3'b000, 1));
    adv();

    // lui
    fetch_decode("lui", 6'h0f, 6'h00);
    chk("lui_iexec", mk(0,0,0,0,0,0,0,1,1, 2'b00,2'b00,2'b01,2'b10, 4'b1000, 2'b00, 3'b000, 0));
    adv();
    chk("lui_wb", mk(0,0,0,0,0,0,1,0,0, 2'b01,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 1));
    adv();

    // Reset asserted mid-MEM_RD wait
    fetch_decode("lw2", 6'h23, 6'h00);
    adv();  // MEM_ADDR -> MEM_RD
    mem_ready = 1'b0;
    chk("lw2_rd_wait", mk(0,0,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 4'b0000, 2'b00, 3'b000, 0));
    #2 reset = 1'b0;
    chk("reset_mid_rd", ZERO);
    adv();
    chk("reset_mid_hold", ZERO);
    reset = 1'b1;
    chk("reset_release", ZERO);
    adv();
    mem_ready = 1'b0;
    chk("post_reset_fetch", e_fetch(1'b0));

    // Illegal opcode 0x3f
    OpCode = 6'h3f; Funct = 6'h00; mem_ready = 1'b1;
    chk("ill_fetch", e_fetch(1'b1));
    adv();
    mem_ready = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    chk("ill_decode", e_decode(1'b0));
    chk1("ill_trap_decode", trap, 1'b0);
    adv();
    mem_ready = 1'b1;
    chk("ill_trap_state", ZERO);
    chk1("ill_trap_hi", trap, 1'b1);
    adv();
    adv();
    chk("ill_trap_held", ZERO);
    chk1("ill_trap_hold", trap, 1'b1);
    reset = 1'b0;
    #1;
    chk1("ill_trap_clear", trap, 1'b0);
    adv();
    reset = 1'b1;
    adv();
    mem_ready = 1'b0;
    chk("trap_exit_fetch", e_fetch(1'b0));
`else
    chk("ill_decode_nop", e_decode(1'b1));
    adv();
    mem_ready = 1'b0;
    chk("ill_back_fetch", e_fetch(1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
